// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch-stage signals: instruction-memory
//               address/data, downstream redirect, and the decode-side
//               valid/ready head port with occupancy.
//               master : the fetch_queue itself
//               slave  : the environment (imem + decode + branch unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch stage with a DEPTH-entry first-word-fall-
//               through prefetch queue. Presents fetch_pc on imem_addr,
//               captures {imem_data, fetch_pc} each cycle there is room,
//               and hands entries to decode over a valid/ready handshake.
//               A redirect flushes the queue and reloads fetch_pc.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - fetch_queue_if.master (imem, redirect, head port)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire            clk,
  input  wire            rst_n,
  fetch_queue_if.master  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  // Redirect masks the head so decode never consumes a wrong-path entry.
  assign w_valid = (count_q != '0) && !bus.redirect;
  assign w_pop   = w_valid && bus.out_ready;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign w_push  = !bus.redirect && ((count_q != C_FULL) || w_pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      // Flush by snapping the read pointer onto the write pointer;
      // stale storage is simply left behind.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (w_push) begin
        instr_q[wr_ptr_q] <= bus.imem_data;
        pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
    end
  end

  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = w_valid;
  assign bus.out_instr    = instr_q[rd_ptr_q];
  assign bus.out_pc       = pc_q[rd_ptr_q];
  assign bus.out_pc_plus4 = pc_q[rd_ptr_q] + 32'd4;
  assign bus.count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A reference queue of
//               {pc, instr} is pushed as each cycle's stimulus is applied
//               and compared against the DUT head port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Memory model: word k lives at byte address 4k.
  assign bus.imem_data = mem_word(bus.imem_addr);

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  bus.imem_addr, RESET_PC);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_instr"}, bus.out_instr, 32'd0);
    check({tag, "_pc"},    bus.out_pc, 32'd0);
    check({tag, "_pc4"},   bus.out_pc_plus4, 32'd4);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  // Apply one cycle of stimulus (called just after a falling edge), check
  // outputs against the reference queue, advance the model, cross the edge.
  task automatic cycle(input logic rdr, input logic [31:0] rpc, input logic rdy);
    logic   exp_valid;
    logic   pop;
    logic   push;
    entry_t e;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    #1;
    exp_valid = (sb_q.size() != 0) && !rdr;
    check("imem_addr", bus.imem_addr, m_pc);
    check("count", 32'(bus.count), 32'(sb_q.size()));
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("out_pc",    bus.out_pc,       sb_q[0].pc);
      check("out_instr", bus.out_instr,    sb_q[0].instr);
      check("out_pc4",   bus.out_pc_plus4, sb_q[0].pc + 32'd4);
    end
    if (rdr) begin
      sb_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      pop  = exp_valid && rdy;
      push = (sb_q.size() < DEPTH) || pop;
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        sb_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges, check outputs react before any edge,
  // then release on a falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb_q.delete();
    m_pc = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready   = 1'b0;
    sb_q.delete();
    m_pc = RESET_PC;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

    // Fill with decode stalled, then drain (covers full+pop edge).
    do_reset("rst1");
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

    // Single full-queue pop/push cycle, then stall again.
    do_reset("rst2");
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'd0, 1'b0);

    // Redirect with three entries queued; low address bits dropped.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h0000_0203, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);

    // Held redirect, then wrap-around at the top of the address space.
    cycle(1'b1, 32'h0000_0400, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);

    // Mid-operation asynchronous reset with three entries queued.
    do_reset("rst4");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    do_reset("rst5");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
